// File: rtl/heart_hud_ctrl.sv
// heart_hud_ctrl
// Lives/HUD controller for the heart sprite. Tracks remaining lives, maps the
// current VGA coordinate onto one of MAX_LIVES heart slots sharing a single
// HEART_SIZE x HEART_SIZE heart ROM, blinks the most recently lost heart for
// BLINK_FRAMES frames and flags game over.
//
// Ports:
//   vga_clk      in   pixel clock, sole clock
//   reset_n      in   asynchronous active-low reset
//   DrawX/DrawY  in   current pixel column/row (10 bits)
//   blank        in   high inside the active display region
//   new_game     in   one-cycle pulse: restore lives and restart
//   life_lost    in   one-cycle pulse: player lost a life
//   rom_address  out  heart ROM address for the current pixel (combinational)
//   heart_pixel  out  registered; rom_q this cycle belongs to a visible heart
//   lives        out  remaining lives (registered)
//   game_over    out  registered; high in GAME_OVER
//   blinking     out  registered; high in BLINK
module heart_hud_ctrl #(
  parameter int MAX_LIVES    = 3,
  parameter int HEART_SIZE   = 25,
  parameter int HUD_X        = 8,
  parameter int HUD_Y        = 8,
  parameter int SPACING      = 30,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_HALF   = 8
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       new_game,
  input  logic       life_lost,
  output logic [9:0] rom_address,
  output logic       heart_pixel,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       blinking
);

  localparam int TIMER_W = $clog2(BLINK_FRAMES + 1);
  localparam int PHASE_W = $clog2(BLINK_HALF + 1);

  localparam logic [1:0] ST_ALIVE     = 2'd0;
  localparam logic [1:0] ST_BLINK     = 2'd1;
  localparam logic [1:0] ST_GAME_OVER = 2'd2;

  localparam logic [2:0]         LIVES_INIT = 3'(MAX_LIVES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(BLINK_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BLINK_HALF - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PHASE_ZERO = PHASE_W'(0);

  // Left edge of HUD slot idx, computed in 20 bits so no product can wrap.
  function automatic logic [19:0] slot_left(input int idx);
    return 20'(HUD_X) + 20'(idx) * 20'(SPACING);
  endfunction

  // Registered state
  logic [1:0]         state_r;
  logic [2:0]         lives_r;
  logic [TIMER_W-1:0] timer_r;
  logic [PHASE_W-1:0] phase_r;
  logic               blink_on_r;
  logic [9:0]         prev_x_r;
  logic [9:0]         prev_y_r;
  logic               heart_pixel_r;
  logic               game_over_r;
  logic               blinking_r;

  // Next-state / decode signals
  logic [1:0]           state_s;
  logic [2:0]           lives_s;
  logic [TIMER_W-1:0]   timer_s;
  logic [PHASE_W-1:0]   phase_s;
  logic                 blink_on_s;
  logic [19:0]          x_s;
  logic [19:0]          y_s;
  logic                 y_in_s;
  logic [MAX_LIVES-1:0] slot_hit_s;
  logic                 hit_s;
  logic [2:0]           hit_idx_s;
  logic [19:0]          left_s;
  logic                 visible_s;
  logic                 tick_s;

  assign x_s    = {10'd0, DrawX};
  assign y_s    = {10'd0, DrawY};
  assign y_in_s = (y_s >= 20'(HUD_Y)) && (y_s < 20'(HUD_Y + HEART_SIZE));

  for (genvar g = 0; g < MAX_LIVES; g++) begin : g_slot
    assign slot_hit_s[g] = y_in_s && (x_s >= slot_left(g))
                           && (x_s < slot_left(g) + 20'(HEART_SIZE));
  end

  assign hit_s = |slot_hit_s;

  // Slot decode: SPACING >= HEART_SIZE keeps slots disjoint, so at most one bit is set.
  always_comb begin
    hit_idx_s = 3'd0;
    left_s    = 20'd0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      hit_idx_s = slot_hit_s[i] ? 3'(i) : hit_idx_s;
      left_s    = slot_hit_s[i] ? slot_left(i) : left_s;
    end
  end

  // Row-major sprite offset; the 20-bit sum is truncated to the 10-bit ROM address.
  assign rom_address = hit_s
    ? 10'((y_s - 20'(HUD_Y)) * 20'(HEART_SIZE) + (x_s - left_s))
    : 10'd0;

  // The slot just above the remaining lives is the one that was lost; it blinks.
  assign visible_s = (hit_idx_s < lives_r)
                     || ((state_r == ST_BLINK) && (hit_idx_s == lives_r) && blink_on_r);

  // Frame start: first cycle at (0,0) after any other coordinate.
  assign tick_s = (DrawX == 10'd0) && (DrawY == 10'd0)
                  && !((prev_x_r == 10'd0) && (prev_y_r == 10'd0));

  // Lives / blink FSM next-state logic.
  always_comb begin
    state_s    = state_r;
    lives_s    = lives_r;
    timer_s    = timer_r;
    phase_s    = phase_r;
    blink_on_s = blink_on_r;
    if (new_game) begin
      state_s    = ST_ALIVE;
      lives_s    = LIVES_INIT;
      timer_s    = TIMER_ZERO;
      phase_s    = PHASE_ZERO;
      blink_on_s = 1'b0;
    end else begin
      case (state_r)
        ST_ALIVE: begin
          if (life_lost) begin
            if (lives_r != 3'd0) begin
              state_s    = ST_BLINK;
              lives_s    = lives_r - 3'd1;
              timer_s    = TIMER_INIT;
              phase_s    = PHASE_ZERO;
              blink_on_s = 1'b0;
            end else begin
              state_s = ST_GAME_OVER;
            end
          end else begin
            state_s = ST_ALIVE;
          end
        end
        ST_BLINK: begin
          if (tick_s) begin
            if (phase_r >= PHASE_LAST) begin
              phase_s    = PHASE_ZERO;
              blink_on_s = ~blink_on_r;
            end else begin
              phase_s = phase_r + PHASE_ONE;
            end
            // timer_r <= 1 also guards a zero timer from wrapping
            if (timer_r <= TIMER_ONE) begin
              timer_s    = TIMER_ZERO;
              blink_on_s = 1'b0;
              state_s    = (lives_r != 3'd0) ? ST_ALIVE : ST_GAME_OVER;
            end else begin
              timer_s = timer_r - TIMER_ONE;
            end
          end else begin
            state_s = ST_BLINK;
          end
        end
        ST_GAME_OVER: begin
          state_s = ST_GAME_OVER;
        end
        default: begin
          state_s    = ST_ALIVE;
          timer_s    = TIMER_ZERO;
          phase_s    = PHASE_ZERO;
          blink_on_s = 1'b0;
        end
      endcase
    end
  end

  // State, coordinate history and registered outputs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_ALIVE;
      lives_r       <= LIVES_INIT;
      timer_r       <= TIMER_ZERO;
      phase_r       <= PHASE_ZERO;
      blink_on_r    <= 1'b0;
      prev_x_r      <= 10'd0;
      prev_y_r      <= 10'd0;
      heart_pixel_r <= 1'b0;
      game_over_r   <= 1'b0;
      blinking_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      lives_r       <= lives_s;
      timer_r       <= timer_s;
      phase_r       <= phase_s;
      blink_on_r    <= blink_on_s;
      prev_x_r      <= DrawX;
      prev_y_r      <= DrawY;
      heart_pixel_r <= blank && hit_s && visible_s;
      game_over_r   <= (state_s == ST_GAME_OVER);
      blinking_r    <= (state_s == ST_BLINK);
    end
  end

  assign heart_pixel = heart_pixel_r;
  assign lives       = lives_r;
  assign game_over   = game_over_r;
  assign blinking    = blinking_r;

endmodule
